counter_seq_ctrl: RTL and testbench
===================================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per count tick; SHALL be legal for values >= 2.
REQ-002 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  level; request to run or resume counting.
REQ-005 stop  input  1  level; request to pause counting.
REQ-006 load_req  input  1  level; request to preload the counter with preset.
REQ-007 preset  input  4  preload value.
REQ-008 dir_mode  input  2  00 up, 01 down, 10 ping-pong, 11 treated as 00.
REQ-009 count_q  input  4  current value fed back from the counter datapath.
REQ-010 tick  output  1  one-cycle count-enable pulse to the counter.
REQ-011 up_down  output  1  1 = count up, 0 = count down.
REQ-012 load  output  1  one-cycle synchronous load strobe to the counter.
REQ-013 data_in  output  4  load value, valid while load=1.
REQ-014 busy  output  1  1 in RUN or LOAD.
REQ-015 state  output  2  IDLE=00, RUN=01, LOAD=10, HOLD=11.

Function
REQ-016 FSM states SHALL be IDLE, RUN, LOAD and HOLD; all outputs SHALL be registered.
REQ-017 Request priority in every state SHALL be load_req > stop > start.
REQ-018 IDLE: load_req -> LOAD; else start -> RUN; else stay.
REQ-019 RUN: load_req -> LOAD; else stop -> HOLD; else stay.
REQ-020 HOLD: load_req -> LOAD; else start with stop=0 -> RUN; else stay.
REQ-021 LOAD SHALL last exactly one cycle, with load=1 and data_in = preset sampled on the cycle LOAD was entered.
REQ-022 LOAD exit: to RUN if entered from RUN, to HOLD if entered from HOLD, to IDLE if entered from IDLE; a load_req still held SHALL NOT re-enter LOAD until it has been seen low.
REQ-023 Prescaler: 0..TICK_DIV-1, increments only in RUN, wraps to 0; tick=1 in the cycle after the prescaler equals TICK_DIV-1; first tick SHALL occur TICK_DIV cycles after entering RUN from IDLE or LOAD.
REQ-024 Prescaler SHALL hold its value in HOLD (resume keeps phase), and clear to 0 in IDLE and LOAD.
REQ-025 tick SHALL be 0 in every state except RUN; a stop or load_req arriving on the terminal prescaler cycle SHALL suppress that tick.
REQ-026 dir_mode 00/11: up_down=1; dir_mode 01: up_down=0; a change SHALL take effect on the next cycle.
REQ-027 Ping-pong: in RUN, when up_down=1 and count_q=15, up_down SHALL go 0 next cycle; when up_down=0 and count_q=0, up_down SHALL go 1 next cycle; flips SHALL be evaluated only in cycles with tick=0.
REQ-028 Entering ping-pong SHALL start with up_down=1 unless count_q=15.
REQ-029 load SHALL never be 1 in the same cycle as tick.
REQ-030 data_in SHALL hold its last loaded value outside LOAD.

Reset
REQ-031 With reset=0 at a clk edge: state=IDLE, prescaler=0, tick=0, load=0, data_in=0, busy=0, up_down=1.
REQ-032 Reset SHALL override all requests, including mid-LOAD and mid-RUN; no load or tick pulse SHALL follow it.
REQ-033 After reset is released, the first transition SHALL be evaluated at the next clk edge.

Verification (TICK_DIV=4)
REQ-034 Reset, start=1 for 1 cycle, dir_mode=00 -> state=RUN, tick pulses every 4 cycles with the first 4 cycles after RUN entry, up_down=1.
REQ-035 In RUN, stop=1 after 2 prescaler counts, then start after 10 cycles -> HOLD with no ticks, then the next tick arrives 2 cycles after RUN re-entry.
REQ-036 preset=5, load_req pulse in RUN -> exactly one cycle load=1, data_in=5, tick=0, then RUN with first tick 4 cycles later.
REQ-037 dir_mode=10, count_q driven 14,15,... -> up_down falls one cycle after count_q=15; count_q=0 -> up_down rises one cycle later.
REQ-038 load_req, stop and start all high in IDLE -> LOAD then IDLE; with load_req held, no second load pulse.
REQ-039 reset=0 asserted during LOAD and during RUN -> next cycle all outputs at reset values, no tick or load.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_ctrl
// Description : Sequencing controller for an external 4-bit up/down counter.
//               Generates a prescaled count-enable tick, count direction
//               (fixed up, fixed down or ping-pong) and a one-cycle preload
//               strobe, under an IDLE/RUN/LOAD/HOLD state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       load_req,
    input  logic [3:0] preset,
    input  logic [1:0] dir_mode,
    input  logic [3:0] count_q,
    output logic       tick,
    output logic       up_down,
    output logic       load,
    output logic [3:0] data_in,
    output logic       busy,
    output logic [1:0] state
);

    localparam int unsigned             c_PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0]    c_TERM    = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_PRESC_W-1:0]    c_ONE     = c_PRESC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_LOAD = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    state_t                 r_state;
    state_t                 r_ret_state;
    state_t                 w_next_state;
    logic [c_PRESC_W-1:0]   r_presc;
    logic                   r_load_armed;
    logic                   r_pp_active;
    logic                   r_tick;
    logic                   r_load;
    logic [3:0]             r_data_in;
    logic                   r_busy;
    logic                   r_up_down;
    logic                   w_next_up_down;
    logic                   w_load_go;
    logic                   w_term;

    // A held load_req only counts once; it must drop low before it can re-trigger.
    assign w_load_go = load_req & r_load_armed;
    assign w_term    = (r_presc == c_TERM);

    // State register; reset wins over every request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ret_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == ST_LOAD && r_state != ST_LOAD) begin
                r_ret_state <= r_state;
            end
        end
    end

    // Next-state logic with load_req > stop > start priority.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load_go)   w_next_state = ST_LOAD;
                else if (stop)   w_next_state = ST_IDLE;
                else if (start)  w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (w_load_go)   w_next_state = ST_LOAD;
                else if (stop)   w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_load_go)           w_next_state = ST_LOAD;
                else if (start && !stop) w_next_state = ST_RUN;
            end
            ST_LOAD: begin
                // LOAD is a single cycle and returns to wherever it came from.
                w_next_state = r_ret_state;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Direction select: fixed up/down, or ping-pong bouncing at 15 and 0.
    always_comb begin
        w_next_up_down = r_up_down;
        case (dir_mode)
            2'b01: w_next_up_down = 1'b0;
            2'b10: begin
                if (!r_pp_active) begin
                    // First cycle in ping-pong: head up unless already at the top.
                    w_next_up_down = (count_q != 4'hF);
                end else if (r_state == ST_RUN && !r_tick) begin
                    // Only re-evaluate between ticks so the counter value is settled.
                    if (r_up_down && count_q == 4'hF)       w_next_up_down = 1'b0;
                    else if (!r_up_down && count_q == 4'h0) w_next_up_down = 1'b1;
                end
            end
            default: w_next_up_down = 1'b1;
        endcase
    end

    // Prescaler, load-arming and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_presc      <= '0;
            r_load_armed <= 1'b1;
            r_pp_active  <= 1'b0;
            r_tick       <= 1'b0;
            r_load       <= 1'b0;
            r_data_in    <= 4'h0;
            r_busy       <= 1'b0;
            r_up_down    <= 1'b1;
        end else begin
            // Counts only while running, keeps phase across HOLD, clears elsewhere.
            case (r_state)
                ST_RUN:  r_presc <= w_term ? '0 : (r_presc + c_ONE);
                ST_HOLD: r_presc <= r_presc;
                default: r_presc <= '0;
            endcase

            if (!load_req) begin
                r_load_armed <= 1'b1;
            end else if (w_next_state == ST_LOAD) begin
                r_load_armed <= 1'b0;
            end

            // A stop or load arriving on the terminal count suppresses the tick.
            r_tick <= (r_state == ST_RUN) && (w_next_state == ST_RUN) && w_term;
            r_load <= (w_next_state == ST_LOAD);
            if (w_next_state == ST_LOAD) begin
                r_data_in <= preset;
            end
            r_busy      <= (w_next_state == ST_RUN) || (w_next_state == ST_LOAD);
            r_up_down   <= w_next_up_down;
            r_pp_active <= (dir_mode == 2'b10);
        end
    end

    assign tick    = r_tick;
    assign load    = r_load;
    assign data_in = r_data_in;
    assign busy    = r_busy;
    assign up_down = r_up_down;
    assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_seq_ctrl
// Description : Self-checking bench for counter_seq_ctrl (TICK_DIV = 4).
//               Directed stimulus pushes hand-computed expected outputs into
//               a queue; a monitor pops one entry per clock and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

    localparam logic [1:0] c_I = 2'b00;
    localparam logic [1:0] c_R = 2'b01;
    localparam logic [1:0] c_L = 2'b10;
    localparam logic [1:0] c_H = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       load_req;
    logic [3:0] preset;
    logic [1:0] dir_mode;
    logic [3:0] count_q;
    logic       tick;
    logic       up_down;
    logic       load;
    logic [3:0] data_in;
    logic       busy;
    logic [1:0] state;

    int         n_checks = 0;
    int         n_fail   = 0;

    logic [9:0] q_exp[$];
    string      q_name[$];

    counter_seq_ctrl #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .load_req (load_req),
        .preset   (preset),
        .dir_mode (dir_mode),
        .count_q  (count_q),
        .tick     (tick),
        .up_down  (up_down),
        .load     (load),
        .data_in  (data_in),
        .busy     (busy),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Push the outputs expected after the next rising edge, then advance one cycle.
    task automatic step(input string name, input logic [1:0] st, input logic tk,
                        input logic ld, input logic ud, input logic [3:0] din);
        logic bz;
        bz = (st == c_R) || (st == c_L);
        q_exp.push_back({st, bz, tk, ld, ud, din});
        q_name.push_back(name);
        @(negedge clk);
    endtask

    task automatic step_n(input string name, input int n, input logic [1:0] st,
                          input logic tk, input logic ld, input logic ud,
                          input logic [3:0] din);
        for (int i = 0; i < n; i++) step(name, st, tk, ld, ud, din);
    endtask

    // Monitor: one comparison per clock, sampled just after the rising edge.
    initial begin
        logic [9:0] exp_v;
        logic [9:0] got_v;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                exp_v = q_exp.pop_front();
                nm    = q_name.pop_front();
                got_v = {state, busy, tick, load, up_down, data_in};
                n_checks++;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s: {state,busy,tick,load,up_down,data_in} got %b expected %b",
                             nm, got_v, exp_v);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; load_req = 1'b0;
        preset = 4'h0; dir_mode = 2'b00; count_q = 4'h0;
        @(negedge clk);

        // Reset values
        step_n("reset", 2, c_I, 0, 0, 1, 4'h0);

        // Start pulse: RUN, tick every 4 cycles, first 4 after entry
        reset = 1'b1; start = 1'b1;
        step("run_entry", c_R, 0, 0, 1, 4'h0);
        start = 1'b0;
        step_n("run_pre", 3, c_R, 0, 0, 1, 4'h0);
        step("tick1", c_R, 1, 0, 1, 4'h0);
        step_n("run_mid", 3, c_R, 0, 0, 1, 4'h0);
        step("tick2", c_R, 1, 0, 1, 4'h0);

        // Stop after two prescaler counts, hold 10 cycles, resume keeps phase
        step("run_c9", c_R, 0, 0, 1, 4'h0);
        stop = 1'b1;
        step("hold_entry", c_H, 0, 0, 1, 4'h0);
        stop = 1'b0;
        step_n("hold", 9, c_H, 0, 0, 1, 4'h0);
        start = 1'b1;
        step("resume", c_R, 0, 0, 1, 4'h0);
        start = 1'b0;
        step("resume1", c_R, 0, 0, 1, 4'h0);
        step("resume_tick", c_R, 1, 0, 1, 4'h0);

        // Load pulse in RUN
        step("run_r3", c_R, 0, 0, 1, 4'h0);
        load_req = 1'b1; preset = 4'h5;
        step("load_pulse", c_L, 0, 1, 1, 4'h5);
        load_req = 1'b0; preset = 4'h9;
        step("load_exit", c_R, 0, 0, 1, 4'h5);
        step_n("post_load", 3, c_R, 0, 0, 1, 4'h5);
        step("load_tick", c_R, 1, 0, 1, 4'h5);

        // Stop on the terminal prescaler cycle suppresses the tick
        step_n("run_k", 3, c_R, 0, 0, 1, 4'h5);
        stop = 1'b1;
        step("stop_on_term", c_H, 0, 0, 1, 4'h5);
        stop = 1'b0; start = 1'b1;
        step("resume2", c_R, 0, 0, 1, 4'h5);
        start = 1'b0;
        step_n("resume2_pre", 3, c_R, 0, 0, 1, 4'h5);
        step("resume2_tick", c_R, 1, 0, 1, 4'h5);

        // Ping-pong direction
        dir_mode = 2'b10; count_q = 4'd14;
        step("pp_entry", c_R, 0, 0, 1, 4'h5);
        count_q = 4'd15;
        step("pp_fall", c_R, 0, 0, 0, 4'h5);
        count_q = 4'd14;
        step("pp_down", c_R, 0, 0, 0, 4'h5);
        count_q = 4'd13;
        step("pp_tick", c_R, 1, 0, 0, 4'h5);
        count_q = 4'd0;
        step("pp_no_flip_on_tick", c_R, 0, 0, 0, 4'h5);
        step("pp_rise", c_R, 0, 0, 1, 4'h5);
        dir_mode = 2'b01;
        step("dir_down", c_R, 0, 0, 0, 4'h5);

        // Reset on the terminal prescaler cycle in RUN: no tick follows
        reset = 1'b0; dir_mode = 2'b00; count_q = 4'h0;
        step("reset_in_run", c_I, 0, 0, 1, 4'h0);
        reset = 1'b1;
        step("post_reset", c_I, 0, 0, 1, 4'h0);

        // All requests high in IDLE: single LOAD back to IDLE, no reload
        load_req = 1'b1; stop = 1'b1; start = 1'b1; preset = 4'h7;
        step("load_idle", c_L, 0, 1, 1, 4'h7);
        step("load_ret_idle", c_I, 0, 0, 1, 4'h7);
        step_n("no_reload", 2, c_I, 0, 0, 1, 4'h7);
        load_req = 1'b0;
        step("stop_blocks_start", c_I, 0, 0, 1, 4'h7);
        stop = 1'b0; start = 1'b0;
        step("idle_quiet", c_I, 0, 0, 1, 4'h7);

        // Reset asserted during LOAD
        start = 1'b1;
        step("run_again", c_R, 0, 0, 1, 4'h7);
        start = 1'b0; load_req = 1'b1; preset = 4'h3;
        step("load_run", c_L, 0, 1, 1, 4'h3);
        reset = 1'b0; load_req = 1'b0;
        step("reset_in_load", c_I, 0, 0, 1, 4'h0);
        reset = 1'b1;
        step_n("post_reset2", 2, c_I, 0, 0, 1, 4'h0);

        // LOAD entered from HOLD returns to HOLD
        start = 1'b1;
        step("run_h", c_R, 0, 0, 1, 4'h0);
        start = 1'b0; stop = 1'b1;
        step("hold_h", c_H, 0, 0, 1, 4'h0);
        stop = 1'b0; load_req = 1'b1; preset = 4'hA;
        step("load_hold", c_L, 0, 1, 1, 4'hA);
        load_req = 1'b0;
        step_n("load_ret_hold", 2, c_H, 0, 0, 1, 4'hA);

        @(negedge clk);
        if (q_exp.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
